// File: rtl/gmii_rx_pkg.sv
// Shared types and elaboration-time helpers for the GMII receive packer.
// Combinational only: no latency and no flow control of its own.
package gmii_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_DROP,
      ST_QUIET
   } rx_state_t;

   // Control fields that travel alongside each packed word.
   typedef struct packed {
      logic sop;
      logic eop;
      logic err;
   } word_ctl_t;

   localparam word_ctl_t CTL_NONE = '{sop: 1'b0, eop: 1'b0, err: 1'b0};
   localparam word_ctl_t CTL_TERM = '{sop: 1'b0, eop: 1'b1, err: 1'b1};

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic bit params_ok(input int data_bytes, input int mod_w, input int len_w,
                                    input int min_len, input int max_len);
      return (data_bytes inside {1, 2, 4, 8}) &&
             (mod_w >= 1) && (mod_w >= clog2(data_bytes)) &&
             (len_w >= 1) && (len_w <= 31) &&
             (max_len >= 1) && (max_len <= (1 << len_w) - 1) &&
             (min_len >= 0) && (min_len <= (1 << len_w) - 1);
   endfunction

endpackage

// File: rtl/gmii_byte_packer.sv
// Packs bytes MSB-first into a word; word_out/word_rdy show the word including this cycle's byte.
// No backpressure: the buffer clears whenever word_rdy is high, whether or not the word is kept.
module gmii_byte_packer #(
   parameter int DATA_BYTES = 4,
   parameter int CNT_W      = 3
) (
   input  logic                    clk_gmii_rx,
   input  logic                    reset,
   input  logic [7:0]              byte_in,
   input  logic                    byte_vld,
   input  logic                    flush,
   output logic [DATA_BYTES*8-1:0] word_out,
   output logic                    word_rdy,
   output logic [CNT_W-1:0]        cnt
);

   logic [DATA_BYTES*8-1:0] pack_buf;
   logic [CNT_W-1:0]        cnt_nxt;

   always_comb begin
      word_out = pack_buf;
      if (byte_vld) begin
         for (int i = 0; i < DATA_BYTES; i++) begin
            if (cnt == CNT_W'(i)) word_out[(DATA_BYTES-1-i)*8 +: 8] = byte_in;
         end
      end
      cnt_nxt  = cnt + CNT_W'(byte_vld);
      word_rdy = (cnt_nxt == CNT_W'(DATA_BYTES)) || (flush && (cnt_nxt != '0));
   end

   // Clearing to zero on every emit is what zero-fills the tail of a short word.
   always_ff @(posedge clk_gmii_rx) begin
      if (reset) begin
         pack_buf <= '0;
         cnt      <= '0;
      end else if (word_rdy) begin
         pack_buf <= '0;
         cnt      <= '0;
      end else if (byte_vld) begin
         pack_buf <= word_out;
         cnt      <= cnt_nxt;
      end
   end

endmodule

// File: rtl/gmii_rx_packer.sv
// GMII receive to frame-FIFO word packer with length limits and error/overflow marking; byte at t is written at t+2 or later.
// Honours i_data_full: a blocked word drops the rest of the frame, and an open frame is closed with an error termination word.
module gmii_rx_packer
   import gmii_rx_pkg::*;
#(
   parameter int DATA_BYTES = 4,
   parameter int MOD_W      = 3,
   parameter int LEN_W      = 11,
   parameter int MIN_LEN    = 64,
   parameter int MAX_LEN    = 1536
) (
   input  logic                    clk_gmii_rx,
   input  logic                    reset,
   input  logic                    i_gmii_dv,
   input  logic [7:0]              iv_gmii_rxd,
   input  logic                    i_gmii_er,
   output logic [DATA_BYTES*8-1:0] ov_data,
   output logic                    o_data_sop,
   output logic                    o_data_eop,
   output logic [MOD_W-1:0]        ov_data_mod,
   output logic                    o_frame_err,
   output logic [LEN_W-1:0]        ov_frame_len,
   output logic                    o_data_wr,
   input  logic                    i_data_full,
   output logic                    o_fifo_overflow_pulse
);

   localparam int CNT_W = clog2(DATA_BYTES) + 1;

   generate
      if (!params_ok(DATA_BYTES, MOD_W, LEN_W, MIN_LEN, MAX_LEN)) begin : g_bad_params
         $error("gmii_rx_packer: illegal parameter combination");
      end
   endgenerate

   logic                    r_dv;
   logic [7:0]              r_rxd;
   logic                    r_er;
   rx_state_t               state;
   logic [LEN_W-1:0]        len;
   logic [LEN_W-1:0]        term_len;
   logic                    err_acc;
   logic                    pend_term;
   logic                    first_word;
   word_ctl_t               ctl_q;

   logic [DATA_BYTES*8-1:0] word_out;
   logic                    word_rdy;
   logic [CNT_W-1:0]        pack_cnt;

   logic                    rise;
   logic                    fend;
   logic                    byte_vld;
   logic                    flush;
   logic                    at_max;
   logic                    runt;
   logic                    err_nxt;
   logic [LEN_W-1:0]        len_inc;
   logic [LEN_W-1:0]        len_sat;
   logic [CNT_W-1:0]        word_bytes;
   logic [MOD_W-1:0]        eop_mod;

   assign rise = !r_dv && i_gmii_dv;
   assign fend = r_dv && !i_gmii_dv;

   always_comb begin
      len_inc    = len + LEN_W'(1);
      len_sat    = (len == '1) ? len : len_inc;
      at_max     = (len_inc == LEN_W'(MAX_LEN));
      runt       = (len_inc < LEN_W'(MIN_LEN));
      err_nxt    = err_acc | r_er;
      byte_vld   = (state == ST_RECV) && r_dv;
      flush      = byte_vld && (fend || at_max);
      word_bytes = pack_cnt + CNT_W'(1);
      eop_mod    = (word_bytes == CNT_W'(DATA_BYTES)) ? '0 : MOD_W'(word_bytes);
   end

   gmii_byte_packer #(
      .DATA_BYTES (DATA_BYTES),
      .CNT_W      (CNT_W)
   ) u_packer (
      .clk_gmii_rx (clk_gmii_rx),
      .reset       (reset),
      .byte_in     (r_rxd),
      .byte_vld    (byte_vld),
      .flush       (flush),
      .word_out    (word_out),
      .word_rdy    (word_rdy),
      .cnt         (pack_cnt)
   );

   // r_dv resets high so a frame already in flight at reset release never looks like a new start.
   always_ff @(posedge clk_gmii_rx) begin
      if (reset) begin
         r_dv                  <= 1'b1;
         r_rxd                 <= '0;
         r_er                  <= 1'b0;
         state                 <= ST_IDLE;
         len                   <= '0;
         term_len              <= '0;
         err_acc               <= 1'b0;
         pend_term             <= 1'b0;
         first_word            <= 1'b0;
         ctl_q                 <= CTL_NONE;
         ov_data               <= '0;
         ov_data_mod           <= '0;
         ov_frame_len          <= '0;
         o_data_wr             <= 1'b0;
         o_fifo_overflow_pulse <= 1'b0;
      end else begin
         r_dv                  <= i_gmii_dv;
         r_rxd                 <= iv_gmii_rxd;
         r_er                  <= i_gmii_er;
         ctl_q                 <= CTL_NONE;
         ov_data               <= '0;
         ov_data_mod           <= '0;
         ov_frame_len          <= '0;
         o_data_wr             <= 1'b0;
         o_fifo_overflow_pulse <= 1'b0;

         if (pend_term && !i_data_full) begin
            o_data_wr    <= 1'b1;
            ctl_q        <= CTL_TERM;
            ov_frame_len <= term_len;
            pend_term    <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (rise) begin
                  if (pend_term) begin
                     o_fifo_overflow_pulse <= 1'b1;
                     state                 <= ST_QUIET;
                  end else begin
                     state      <= ST_RECV;
                     len        <= '0;
                     err_acc    <= 1'b0;
                     first_word <= 1'b1;
                  end
               end
            end
            ST_RECV: begin
               if (byte_vld) begin
                  len     <= len_inc;
                  err_acc <= err_nxt;
                  if (word_rdy) begin
                     first_word <= 1'b0;
                     if (i_data_full) begin
                        o_fifo_overflow_pulse <= 1'b1;
                        if (first_word) begin
                           state <= fend ? ST_IDLE : ST_QUIET;
                        end else if (fend) begin
                           pend_term <= 1'b1;
                           term_len  <= len_inc;
                           state     <= ST_IDLE;
                        end else begin
                           state <= ST_DROP;
                        end
                     end else begin
                        o_data_wr <= 1'b1;
                        ov_data   <= word_out;
                        ctl_q     <= '{sop: first_word, eop: flush,
                                       err: flush && (err_nxt || runt || at_max)};
                        if (flush) begin
                           ov_data_mod  <= eop_mod;
                           ov_frame_len <= len_inc;
                           state        <= fend ? ST_IDLE : ST_QUIET;
                        end
                     end
                  end
               end
            end
            ST_DROP: begin
               if (r_dv) begin
                  len <= len_sat;
                  if (fend) begin
                     state <= ST_IDLE;
                     if (!i_data_full) begin
                        o_data_wr    <= 1'b1;
                        ctl_q        <= CTL_TERM;
                        ov_frame_len <= len_sat;
                     end else begin
                        pend_term <= 1'b1;
                        term_len  <= len_sat;
                     end
                  end
               end
            end
            ST_QUIET: begin
               if (fend) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_data_sop  = ctl_q.sop;
   assign o_data_eop  = ctl_q.eop;
   assign o_frame_err = ctl_q.err;

endmodule

// File: tb/tb_gmii_rx_packer.sv
// Directed bench for gmii_rx_packer with DATA_BYTES=4 and MAX_LEN=100.
module tb_gmii_rx_packer;

   localparam int DB      = 4;
   localparam int MOD_W   = 3;
   localparam int LEN_W   = 11;
   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 100;

   logic                 clk_gmii_rx = 1'b0;
   logic                 reset       = 1'b1;
   logic                 i_gmii_dv   = 1'b0;
   logic [7:0]           iv_gmii_rxd = 8'h00;
   logic                 i_gmii_er   = 1'b0;
   logic                 i_data_full = 1'b0;
   logic [DB*8-1:0]      ov_data;
   logic                 o_data_sop;
   logic                 o_data_eop;
   logic [MOD_W-1:0]     ov_data_mod;
   logic                 o_frame_err;
   logic [LEN_W-1:0]     ov_frame_len;
   logic                 o_data_wr;
   logic                 o_fifo_overflow_pulse;

   gmii_rx_packer #(
      .DATA_BYTES (DB),
      .MOD_W      (MOD_W),
      .LEN_W      (LEN_W),
      .MIN_LEN    (MIN_LEN),
      .MAX_LEN    (MAX_LEN)
   ) dut (
      .clk_gmii_rx           (clk_gmii_rx),
      .reset                 (reset),
      .i_gmii_dv             (i_gmii_dv),
      .iv_gmii_rxd           (iv_gmii_rxd),
      .i_gmii_er             (i_gmii_er),
      .ov_data               (ov_data),
      .o_data_sop            (o_data_sop),
      .o_data_eop            (o_data_eop),
      .ov_data_mod           (ov_data_mod),
      .o_frame_err           (o_frame_err),
      .ov_frame_len          (ov_frame_len),
      .o_data_wr             (o_data_wr),
      .i_data_full           (i_data_full),
      .o_fifo_overflow_pulse (o_fifo_overflow_pulse)
   );

   always #5 clk_gmii_rx = ~clk_gmii_rx;

   typedef struct {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic        err;
      logic [10:0] len;
      int          cyc;
   } wr_t;

   wr_t  wq[$];
   int   cyc           = 0;
   int   pulses        = 0;
   int   wr_under_full = 0;
   int   last_cyc      = 0;
   logic full_seen     = 1'b0;
   int   checks        = 0;
   int   errors        = 0;

   always @(posedge clk_gmii_rx) begin
      cyc       <= cyc + 1;
      full_seen <= i_data_full;
   end

   always @(negedge clk_gmii_rx) begin
      if (o_data_wr) begin
         wq.push_back('{data: ov_data, sop: o_data_sop, eop: o_data_eop, mod: ov_data_mod,
                        err: o_frame_err, len: ov_frame_len, cyc: cyc});
         if (full_seen) wr_under_full++;
      end
      if (o_fifo_overflow_pulse) pulses++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wq.delete();
      pulses = 0;
   endtask

   // full is high while byte full_lo..full_hi-1 is on the wire; hold_full keeps it high afterwards.
   task automatic send_frame(input int n, input int er_at, input int full_lo, input int full_hi,
                             input bit hold_full);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_gmii_rx); #1;
         i_gmii_dv   = 1'b1;
         iv_gmii_rxd = 8'(i);
         i_gmii_er   = (i == er_at);
         i_data_full = (i >= full_lo && i < full_hi) || (hold_full && i >= full_lo);
         last_cyc    = cyc;
      end
      @(posedge clk_gmii_rx); #1;
      i_gmii_dv   = 1'b0;
      iv_gmii_rxd = 8'h00;
      i_gmii_er   = 1'b0;
      i_data_full = hold_full;
      repeat (5) @(posedge clk_gmii_rx);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk_gmii_rx);
      @(negedge clk_gmii_rx);
      chk("reset_outputs", {ov_data, o_data_sop, o_data_eop, ov_data_mod, o_frame_err,
                            ov_frame_len, o_data_wr, o_fifo_overflow_pulse}, 64'd0);
      @(posedge clk_gmii_rx); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk_gmii_rx);
      #1;

      // 64-byte frame, FIFO never full
      clear_log();
      send_frame(64, -1, -1, -1, 1'b0);
      chk("t64_writes", wq.size(), 16);
      chk("t64_first", {wq[0].data, wq[0].sop, wq[0].eop}, {32'h00010203, 1'b1, 1'b0});
      chk("t64_mid_sop", wq[7].sop, 1'b0);
      chk("t64_last", {wq[$].data, wq[$].eop, wq[$].mod, wq[$].err, wq[$].len},
                      {32'h3C3D3E3F, 1'b1, 3'd0, 1'b0, 11'd64});
      chk("t64_latency", wq[$].cyc, last_cyc + 2);
      chk("t64_pulses", pulses, 0);

      // 65-byte frame: single byte in the last word
      clear_log();
      send_frame(65, -1, -1, -1, 1'b0);
      chk("t65_writes", wq.size(), 17);
      chk("t65_last", {wq[$].data, wq[$].eop, wq[$].mod, wq[$].err, wq[$].len},
                      {32'h40000000, 1'b1, 3'd1, 1'b0, 11'd65});
      chk("t65_nonlast_len", {wq[15].eop, wq[15].len, wq[15].mod}, 64'd0);

      // 10-byte runt
      clear_log();
      send_frame(10, -1, -1, -1, 1'b0);
      chk("runt_writes", wq.size(), 3);
      chk("runt_last", {wq[$].data, wq[$].eop, wq[$].mod, wq[$].err, wq[$].len},
                       {32'h08090000, 1'b1, 3'd2, 1'b1, 11'd10});

      // 70-byte frame with a GMII error on byte 3
      clear_log();
      send_frame(70, 3, -1, -1, 1'b0);
      chk("er70_writes", wq.size(), 18);
      chk("er70_last", {wq[$].data, wq[$].eop, wq[$].mod, wq[$].err, wq[$].len},
                       {32'h44450000, 1'b1, 3'd2, 1'b1, 11'd70});

      // full only for word 5: drop, then immediate termination
      clear_log();
      send_frame(64, -1, 20, 21, 1'b0);
      chk("full5_pulses", pulses, 1);
      chk("full5_writes", wq.size(), 5);
      chk("full5_word4", {wq[3].data, wq[3].eop}, {32'h0C0D0E0F, 1'b0});
      chk("full5_term", {wq[4].data, wq[4].sop, wq[4].eop, wq[4].mod, wq[4].err, wq[4].len},
                        {32'h0, 1'b0, 1'b1, 3'd0, 1'b1, 11'd64});

      // full held past frame end: deferred termination, next frame dropped
      clear_log();
      send_frame(64, -1, 20, 0, 1'b1);
      chk("hold_writes_before", wq.size(), 4);
      send_frame(8, -1, 0, 0, 1'b1);
      chk("hold_pulses", pulses, 2);
      chk("hold_no_term_yet", wq.size(), 4);
      @(posedge clk_gmii_rx); #1;
      i_data_full = 1'b0;
      repeat (4) @(posedge clk_gmii_rx);
      #1;
      chk("hold_writes_after", wq.size(), 5);
      chk("hold_term", {wq[$].data, wq[$].eop, wq[$].mod, wq[$].err, wq[$].len},
                       {32'h0, 1'b1, 3'd0, 1'b1, 11'd64});

      // 120-byte frame against MAX_LEN=100
      clear_log();
      send_frame(120, -1, -1, -1, 1'b0);
      chk("max_writes", wq.size(), 25);
      chk("max_last", {wq[$].data, wq[$].eop, wq[$].mod, wq[$].err, wq[$].len},
                      {32'h60616263, 1'b1, 3'd0, 1'b1, 11'd100});
      chk("max_pulses", pulses, 0);

      // reset mid-frame, released while dv is still high
      clear_log();
      for (int i = 0; i < 64; i++) begin
         @(posedge clk_gmii_rx); #1;
         i_gmii_dv   = 1'b1;
         iv_gmii_rxd = 8'(i);
         if (i == 20) reset = 1'b1;
         if (i == 23) begin
            reset = 1'b0;
            wq.delete();
            pulses = 0;
         end
         if (i == 22) begin
            @(negedge clk_gmii_rx);
            chk("midreset_outputs", {ov_data, o_data_sop, o_data_eop, ov_data_mod, o_frame_err,
                                     ov_frame_len, o_data_wr, o_fifo_overflow_pulse}, 64'd0);
         end
      end
      @(posedge clk_gmii_rx); #1;
      i_gmii_dv   = 1'b0;
      iv_gmii_rxd = 8'h00;
      repeat (5) @(posedge clk_gmii_rx);
      #1;
      chk("midreset_tail_writes", wq.size(), 0);
      chk("midreset_tail_pulses", pulses, 0);

      clear_log();
      send_frame(64, -1, -1, -1, 1'b0);
      chk("after_reset_writes", wq.size(), 16);
      chk("after_reset_first", {wq[0].data, wq[0].sop}, {32'h00010203, 1'b1});
      chk("after_reset_last", {wq[$].eop, wq[$].err, wq[$].len}, {1'b1, 1'b0, 11'd64});

      chk("no_write_while_full", wr_under_full, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gmii_rx_packer.md
Name: gmii_rx_packer

Overview:
Parametrised successor to the single-byte GMII receive writer. It samples a GMII receive stream and packs bytes into DATA_BYTES-wide words for the receive frame FIFO. Each word carries SOP/EOP markers and a valid-byte count. It also enforces frame length limits, flags GMII errors, runts and overflows, and reports overflow drops without ever leaving a half-written frame open in the FIFO. It sits between the PHY GMII receive pins and the network_rx frame FIFO, in the clk_gmii_rx domain.

Parameters:
DATA_BYTES, 4, bytes per output word; legal values 1, 2, 4, 8.
MOD_W, 3, width of ov_data_mod; must be at least clog2(DATA_BYTES) and at least 1.
LEN_W, 11, width of the frame length counter.
MIN_LEN, 64, frames shorter than this many bytes are flagged as errors.
MAX_LEN, 1536, maximum bytes written per frame; must be at most 2^LEN_W-1.

Ports:
clk_gmii_rx  in  1  GMII receive clock.
reset  in  1  Synchronous, active-high reset.
i_gmii_dv  in  1  GMII data valid.
iv_gmii_rxd  in  8  GMII receive byte.
i_gmii_er  in  1  GMII receive error.
ov_data  out  DATA_BYTES*8  Packed word. Byte 0 of the word occupies the MSBs; unused bytes are zero.
o_data_sop  out  1  First word of a frame.
o_data_eop  out  1  Last word of a frame.
ov_data_mod  out  MOD_W  Valid bytes in an EOP word; 0 means all bytes valid. Zero on non-EOP words.
o_frame_err  out  1  Valid on EOP words; 1 means downstream must discard the frame.
ov_frame_len  out  LEN_W  Frame byte count, valid on EOP words; otherwise 0.
o_data_wr  out  1  FIFO write strobe.
i_data_full  in  1  FIFO full; no write may be issued while it is high.
o_fifo_overflow_pulse  out  1  One-cycle pulse per frame that is dropped or cut short by a full FIFO.

Behaviour:
- Input stage: registers r_dv, r_rxd, r_er. The reset value of r_dv is 1. Because SOP requires a rising edge of dv (r_dv=0 and i_gmii_dv=1), releasing reset in the middle of a frame ignores the remainder of that frame.
- Frame end is detected when r_dv=1 and i_gmii_dv=0.
- Reset: all outputs are 0, the state is IDLE, the pack buffer, byte count and length counter are cleared, and pend_term is 0.
- States:
  - IDLE: on dv rising edge go to RECV, and latch err_acc = 0 and len = 0.
  - RECV: each cycle with r_dv=1 shifts r_rxd into the pack buffer, increments len, and ORs r_er into err_acc. A word is emitted when DATA_BYTES bytes have been collected, when the frame ends, or when len reaches MAX_LEN.
  - DROP: waits for the frame end, then returns to IDLE.
  - QUIET: waits for the frame end, then returns to IDLE; no termination word is required.
- Latency: a byte present on iv_gmii_rxd in cycle t appears in a write no earlier than t+2. The last byte of a frame always appears at exactly t+2.
- EOP word contents:
  - ov_data_mod = len mod DATA_BYTES, with 0 meaning a full word.
  - ov_frame_len = len.
  - o_frame_err = err_acc OR (len < MIN_LEN) OR truncated.
- When the buffer becomes full in the same cycle the frame ends, exactly one word is written, with eop=1 and mod=0.
- A frame of 1 to DATA_BYTES bytes is written as a single word with sop=1 and eop=1.
- Max length: the word that completes MAX_LEN bytes is written with eop=1, o_frame_err=1 and ov_frame_len=MAX_LEN. The block then enters QUIET. No overflow pulse is raised.
- Full at the SOP word: nothing is written, o_fifo_overflow_pulse is raised, and the block enters QUIET. No termination is needed because no SOP reached the FIFO.
- Full at a later word:
  - The word is discarded, o_fifo_overflow_pulse is raised, and the block enters DROP.
  - At frame end, if i_data_full=0, write a termination word: data=0, eop=1, err=1, mod=0, len = bytes received.
  - Otherwise set pend_term.
- pend_term handling:
  - While pend_term is set, the block writes the termination word in the first cycle with i_data_full=0, then clears pend_term.
  - A dv rising edge while pend_term is set drops that whole frame: pulse raised, block enters QUIET, pend_term keeps priority.
- o_data_wr is never asserted in a cycle where i_data_full=1 was sampled.
- o_fifo_overflow_pulse fires at most once per frame.
- i_gmii_er outside dv is ignored.

Decomposition:
- Package gmii_rx_pkg holds:
  - state encodings (IDLE, RECV, DROP, QUIET);
  - the EOP/termination word field layout;
  - a clog2 function;
  - parameter legality checks.
- Sub-module gmii_byte_packer: shift/pack register with byte counter, flush and zero-fill. Its interface is byte_in, byte_vld, flush, word_out, word_rdy and cnt.

Test Plan:
- DATA_BYTES=4, 64-byte frame 0x00..0x3F, FIFO never full:
  - 16 writes;
  - first write is 0x00010203 with sop=1;
  - last write is 0x3C3D3E3F with eop=1, mod=0, len=64, err=0;
  - last write occurs 2 cycles after the last dv byte.
- 65-byte frame:
  - 17 writes;
  - the last write is 0x40000000 with eop=1, mod=1, len=65, err=0.
- 10-byte runt with i_gmii_er pulsed on byte 3 of a 70-byte frame:
  - runt gives 3 writes, last has mod=2, len=10, err=1;
  - 70-byte frame gives err=1, len=70.
- i_data_full high for word 5 of a 64-byte frame:
  - a single pulse, with 4 words written;
  - after dv falls, a termination word data=0, eop=1, err=1, len=64;
  - with full still held at frame end, the termination is deferred until full drops, and the next frame arriving meanwhile is dropped with a pulse.
- MAX_LEN=100 with a 120-byte frame:
  - 25 writes;
  - the last write has eop=1, err=1, len=100;
  - no pulse, and nothing more is written until the next frame.
- Reset asserted mid-frame and released while dv is still high:
  - all outputs are 0 during reset;
  - no writes occur for the remainder of that frame;
  - the next frame is received normally.
